mem_stage_ctrl: RTL

- MEM-stage controller that consumes the registered EX/MEM pipeline outputs.
- Drives the data memory through a req/ready handshake that may take several cycles, and stalls the pipeline while an access is outstanding.
- Registers the write-back fields (MEM/WB). These also serve as the forwarding source for the hazard unit.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/mem_stage_ctrl.sv | 113 +++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: datapath widths, MEM-stage state encoding and
// the write-back bundle handed from MEM to WB.
package cpu_pkg;
   localparam int DATA_W = 8;
   localparam int REG_W  = 3;

   typedef enum logic {IDLE, ACCESS} mem_state_t;

   typedef struct packed {
      logic              write_reg;
      logic [REG_W-1:0]  regD;
      logic [DATA_W-1:0] data;
   } wb_bundle_t;
endpackage

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: runs the data-memory req/ready handshake, stalls the
// pipeline while an access is outstanding and holds the MEM/WB registers.
module mem_stage_ctrl
   import cpu_pkg::*;
#(
   parameter int DATA_W  = cpu_pkg::DATA_W,
   parameter int REG_W   = cpu_pkg::REG_W,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              read_mem_i,
   input  logic              write_mem_i,
   input  logic              write_reg_i,
   input  logic [DATA_W-1:0] aluOut_i,
   input  logic [DATA_W-1:0] data2_i,
   input  logic [REG_W-1:0]  regD_i,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [DATA_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ready_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              stall_o,
   output logic              wb_write_reg_o,
   output logic [REG_W-1:0]  wb_regD_o,
   output logic [DATA_W-1:0] wb_data_o,
   output logic              err_o
);

   mem_state_t        state, state_nxt;
   logic [7:0]        cnt;
   logic              access, timeout;
   logic              lat_we, lat_wr;
   logic [DATA_W-1:0] lat_addr, lat_wdata;
   logic [REG_W-1:0]  lat_regD;
   wb_bundle_t        wb_q;

   assign access  = read_mem_i | write_mem_i;
   // Fires in the last permitted ACCESS cycle so stall can drop the same cycle.
   assign timeout = (state == ACCESS) && !mem_ready_i && (cnt == 8'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (access) state_nxt = ACCESS;
         ACCESS: if (mem_ready_i || timeout) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Stall is gated by reset so a held load cannot freeze the pipe while in reset.
   always_comb begin
      mem_req_o = (state == ACCESS);
      stall_o   = 1'b0;
      if (!reset) begin
         if (state == IDLE) stall_o = access;
         else               stall_o = !mem_ready_i && !timeout;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= '0;
         lat_we    <= 1'b0;
         lat_wr    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_regD  <= '0;
         wb_q      <= '0;
         err_o     <= 1'b0;
      end else if (state == IDLE) begin
         if (access) begin
            lat_addr        <= aluOut_i;
            lat_wdata       <= data2_i;
            lat_we          <= !read_mem_i;   // read wins when both are set
            lat_regD        <= regD_i;
            lat_wr          <= write_reg_i;
            cnt             <= '0;
            wb_q.write_reg  <= 1'b0;
            if (read_mem_i && write_mem_i) err_o <= 1'b1;
         end else begin
            wb_q <= '{write_reg: write_reg_i, regD: regD_i, data: aluOut_i};
         end
      end else begin
         if (mem_ready_i) begin
            cnt <= '0;
            if (!lat_we) wb_q <= '{write_reg: lat_wr, regD: lat_regD, data: mem_rdata_i};
            else         wb_q.write_reg <= 1'b0;
         end else if (timeout) begin
            cnt            <= '0;
            err_o          <= 1'b1;
            wb_q.write_reg <= 1'b0;
         end else begin
            cnt            <= cnt + 8'd1;
            wb_q.write_reg <= 1'b0;
         end
      end
   end

   assign mem_we_o       = lat_we;
   assign mem_addr_o     = lat_addr;
   assign mem_wdata_o    = lat_wdata;
   assign wb_write_reg_o = wb_q.write_reg;
   assign wb_regD_o      = wb_q.regD;
   assign wb_data_o      = wb_q.data;

endmodule
